// File: rtl/axis_sa_requant_if.sv
// AXI-stream style bundle (valid/ready/last + packed lanes) used on both sides of the requantizer.
interface axis_sa_requant_if #(
  parameter int LANES = 4,
  parameter int W     = 16
) ();
  logic                      valid;
  logic                      ready;
  logic                      last;
  logic [LANES-1:0][W-1:0]   data;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/axis_sa_requant.sv
// Requantizes R-lane accumulator beats (round half-up shift, saturate) and serializes
// each beat into R/P narrower output beats, keeping packet boundaries.
module axis_sa_requant #(
  parameter int R  = 4,
  parameter int WY = 16,
  parameter int WO = 8,
  parameter int P  = 2,
  parameter int SW = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [SW-1:0]      shift,
  axis_sa_requant_if.slave   s,
  axis_sa_requant_if.master  m
);

  localparam int N    = R / P;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int MAXV = 2**(WO-1) - 1;
  localparam int MINV = -(2**(WO-1));

  localparam logic [IW-1:0]        IDX_LAST  = IW'(N - 1);
  localparam logic signed [WY:0]   SAT_MAX   = (WY+1)'(MAXV);
  localparam logic signed [WY:0]   SAT_MIN   = (WY+1)'(MINV);
  localparam logic [WO-1:0]        SAT_MAX_O = WO'(MAXV);
  localparam logic [WO-1:0]        SAT_MIN_O = WO'(MINV);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [WO-1:0]     q_reg [R];
  logic              last_q_reg;
  logic [WO-1:0]     req [R];
  logic [SW-1:0]     sh_eff;
  logic              accept;

  // Shifts of WY or more would discard the sign entirely; clamp to WY-1.
  assign sh_eff = ({1'b0, shift} >= (SW+1)'(WY)) ? SW'(WY - 1) : shift;

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_lane
      logic signed [WY:0] ext;
      logic signed [WY:0] bias;
      logic signed [WY:0] sum;
      logic signed [WY:0] shd;

      // One guard bit keeps ext + 2^(sh-1) from overflowing for any legal shift.
      assign ext  = {s.data[gi][WY-1], s.data[gi]};
      assign bias = (sh_eff == '0) ? '0 : ((WY+1)'(1) << (sh_eff - 1'b1));
      assign sum  = ext + bias;
      assign shd  = sum >>> sh_eff;
      assign req[gi] = (shd > SAT_MAX) ? SAT_MAX_O :
                       (shd < SAT_MIN) ? SAT_MIN_O : shd[WO-1:0];
    end
  endgenerate

  assign s.ready = (state_reg == EMPTY) || (m.ready && (idx_reg == IDX_LAST));
  assign accept  = s.valid && s.ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= EMPTY;
      idx_reg    <= '0;
      last_q_reg <= 1'b0;
      for (int i = 0; i < R; i++) q_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (accept) begin
        last_q_reg <= s.last;
        for (int i = 0; i < R; i++) q_reg[i] <= req[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = FULL;
          idx_next   = '0;
        end
      end
      FULL: begin
        if (m.ready) begin
          if (idx_reg != IDX_LAST) begin
            idx_next = idx_reg + 1'b1;
          end else if (accept) begin
            // Drain of the final sub-beat overlaps the next accept: no bubble.
            state_next = FULL;
            idx_next   = '0;
          end else begin
            state_next = EMPTY;
            idx_next   = '0;
          end
        end
      end
      default: begin
        state_next = EMPTY;
        idx_next   = '0;
      end
    endcase
  end

  assign m.valid = (state_reg == FULL);
  assign m.last  = last_q_reg && (idx_reg == IDX_LAST);

  always_comb begin
    m.data = '0;
    for (int n = 0; n < N; n++) begin
      if (idx_reg == IW'(n)) begin
        for (int p = 0; p < P; p++) m.data[p] = q_reg[n*P + p];
      end
    end
  end

endmodule

// File: tb/tb_axis_sa_requant.sv
// Scoreboard bench for axis_sa_requant: a P=2 instance for most scenarios plus a P=4
// instance for the single-beat-per-input streaming case.
module tb_axis_sa_requant;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [3:0] shift;
  int         cyc;
  int         n_checks;
  int         n_fail;
  exp_t       q2[$];
  exp_t       q4[$];

  axis_sa_requant_if #(.LANES(4), .W(16)) s2 ();
  axis_sa_requant_if #(.LANES(2), .W(8))  m2 ();
  axis_sa_requant_if #(.LANES(4), .W(16)) s4 ();
  axis_sa_requant_if #(.LANES(4), .W(8))  m4 ();

  axis_sa_requant #(.R(4), .WY(16), .WO(8), .P(2), .SW(4)) dut2 (
    .clk(clk), .rstn(rstn), .shift(shift), .s(s2), .m(m2)
  );
  axis_sa_requant #(.R(4), .WY(16), .WO(8), .P(4), .SW(4)) dut4 (
    .clk(clk), .rstn(rstn), .shift(shift), .s(s4), .m(m4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rq(input int x, input int sh);
    int s;
    int v;
    s = (sh >= 16) ? 15 : sh;
    v = x;
    if (s > 0) v = v + (1 << (s - 1));
    v = v >>> s;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic logic [63:0] pack_in(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic push_exp(input int sel, input int a, input int b, input int c, input int d,
                          input logic last);
    exp_t e;
    if (sel == 2) begin
      e.d = {16'h0, b[7:0], a[7:0]}; e.last = 1'b0; q2.push_back(e);
      e.d = {16'h0, d[7:0], c[7:0]}; e.last = last; q2.push_back(e);
    end else begin
      e.d = {d[7:0], c[7:0], b[7:0], a[7:0]}; e.last = last; q4.push_back(e);
    end
  endtask

  task automatic drive_beat(input int sel, input logic [63:0] d, input logic last,
                            input logic [3:0] sh);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    shift = sh;
    if (sel == 2) begin s2.valid = 1'b1; s2.data = d; s2.last = last; end
    else          begin s4.valid = 1'b1; s4.data = d; s4.last = last; end
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = (sel == 2) ? s2.ready : s4.ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (sel == 2) s2.valid = 1'b0; else s4.valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL drive_accept dut%0d: s_ready never seen, required within 50 cycles", sel);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({m2.valid, m2.last, m2.data} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid/last/data=%b/%b/%h, required 0/0/0000", m2.valid, m2.last, m2.data);
    end
    n_checks++;
    if (m4.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid4: m_valid=%b, required 0", m4.valid);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({s2.ready, s4.ready, m2.valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release: s_ready2/s_ready4/m_valid=%b%b%b, required 110", s2.ready, s4.ready, m2.valid);
    end
    $display("[%0t] reset done", $time);
  endtask

  task automatic test_requant();
    int   w;
    exp_t e;
    m2.ready = 1'b1;
    push_exp(2, 2, 1, -1, 127, 1'b1);
    push_exp(2, -128, 100, -128, 127, 1'b1);
    push_exp(2, -1, 2, 0, 1, 1'b1);
    fork
      begin
        drive_beat(2, pack_in(24, 23, -24, 32767), 1'b1, 4'd4);
        drive_beat(2, pack_in(-200, 100, -128, 127), 1'b1, 4'd0);
        drive_beat(2, pack_in(-3, 3, -1, 1), 1'b1, 4'd1);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          w = 0;
          do begin @(negedge clk); w++; end while (!(m2.valid && m2.ready) && w < 50);
          n_checks++;
          if (!(m2.valid && m2.ready) || q2.size() == 0) begin
            n_fail++;
            $display("FAIL requant_beat%0d: m_valid=%b queued=%0d, required a beat", k, m2.valid, q2.size());
          end else begin
            e = q2.pop_front();
            $display("[%0t] requant beat%0d data=%h last=%b", $time, k, m2.data, m2.last);
            n_checks++;
            if ({m2.data, m2.last} !== {e.d[15:0], e.last}) begin
              n_fail++;
              $display("FAIL requant_data%0d: data/last=%h/%b, required %h/%b", k, m2.data, m2.last, e.d[15:0], e.last);
            end
            if (k % 2 == 0) begin
              n_checks++;
              if (s2.ready !== 1'b0) begin
                n_fail++;
                $display("FAIL requant_sready%0d: s_ready=%b, required 0", k, s2.ready);
              end
            end
          end
        end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int          w;
    exp_t        e;
    logic [15:0] held;
    m2.ready = 1'b0;
    push_exp(2, 10, -20, 127, -128, 1'b1);
    drive_beat(2, pack_in(10, -20, 300, -300), 1'b1, 4'd0);
    held  = m2.data;
    shift = 4'd9;
    n_checks++;
    if ({m2.valid, held} !== {1'b1, q2[0].d[15:0]}) begin
      n_fail++;
      $display("FAIL bp_first: valid/data=%b/%h, required 1/%h", m2.valid, held, q2[0].d[15:0]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("[%0t] backpressure hold%0d data=%h last=%b", $time, i, m2.data, m2.last);
      n_checks++;
      if ({m2.valid, m2.data, m2.last, s2.ready} !== {1'b1, held, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid/data/last/s_ready=%b/%h/%b/%b, required 1/%h/0/0",
                 i, m2.valid, m2.data, m2.last, s2.ready, held);
      end
    end
    @(posedge clk); #1;
    m2.ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (!(m2.valid && m2.ready) && w < 50);
      n_checks++;
      if (!(m2.valid && m2.ready) || q2.size() == 0) begin
        n_fail++;
        $display("FAIL bp_beat%0d: m_valid=%b queued=%0d, required a beat", k, m2.valid, q2.size());
      end else begin
        e = q2.pop_front();
        $display("[%0t] backpressure beat%0d data=%h last=%b", $time, k, m2.data, m2.last);
        n_checks++;
        if ({m2.data, m2.last} !== {e.d[15:0], e.last}) begin
          n_fail++;
          $display("FAIL bp_data%0d: data/last=%h/%b, required %h/%b", k, m2.data, m2.last, e.d[15:0], e.last);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int          x [3][4];
    logic [3:0]  shv [3];
    int          w;
    int          first;
    exp_t        e;
    shv[0] = 4'd3; shv[1] = 4'd15; shv[2] = 4'd7;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) x[i][j] = int'($urandom_range(0, 65535)) - 32768;
    x[1][0] = 32767; x[1][1] = -32768;
    m2.ready = 1'b1;
    m4.ready = 1'b1;
    for (int sel = 2; sel <= 4; sel += 2) begin
      for (int i = 0; i < 3; i++)
        push_exp(sel, rq(x[i][0], int'(shv[i])), rq(x[i][1], int'(shv[i])),
                 rq(x[i][2], int'(shv[i])), rq(x[i][3], int'(shv[i])), i == 2);
      first = 0;
      fork
        begin
          for (int i = 0; i < 3; i++)
            drive_beat(sel, pack_in(x[i][0], x[i][1], x[i][2], x[i][3]), i == 2, shv[i]);
        end
        begin
          for (int k = 0; k < ((sel == 2) ? 6 : 3); k++) begin
            w = 0;
            if (sel == 2) begin
              do begin @(negedge clk); w++; end while (!(m2.valid && m2.ready) && w < 50);
            end else begin
              do begin @(negedge clk); w++; end while (!(m4.valid && m4.ready) && w < 50);
            end
            if (k == 0) first = cyc;
            n_checks++;
            if (((sel == 2) ? !m2.valid : !m4.valid) || ((sel == 2) ? q2.size() : q4.size()) == 0) begin
              n_fail++;
              $display("FAIL stream%0d_beat%0d: no beat or no expectation, required a beat", sel, k);
            end else begin
              e = (sel == 2) ? q2.pop_front() : q4.pop_front();
              if (sel == 2) begin
                $display("[%0t] stream2 beat%0d data=%h last=%b", $time, k, m2.data, m2.last);
                n_checks++;
                if ({m2.data, m2.last} !== {e.d[15:0], e.last}) begin
                  n_fail++;
                  $display("FAIL stream2_data%0d: data/last=%h/%b, required %h/%b", k, m2.data, m2.last, e.d[15:0], e.last);
                end
              end else begin
                $display("[%0t] stream4 beat%0d data=%h last=%b", $time, k, m4.data, m4.last);
                n_checks++;
                if ({m4.data, m4.last} !== {e.d, e.last}) begin
                  n_fail++;
                  $display("FAIL stream4_data%0d: data/last=%h/%b, required %h/%b", k, m4.data, m4.last, e.d, e.last);
                end
              end
              n_checks++;
              if (cyc !== first + k) begin
                n_fail++;
                $display("FAIL stream%0d_gap%0d: beat at cycle %0d, required %0d", sel, k, cyc, first + k);
              end
            end
          end
        end
      join
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midpacket();
    int   w;
    int   stale;
    exp_t e;
    m2.ready = 1'b0;
    drive_beat(2, pack_in(1000, 2000, 3000, 4000), 1'b1, 4'd2);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({m2.valid, m2.last, m2.data} !== 18'h0) begin
      n_fail++;
      $display("FAIL midreset_async: valid/last/data=%b/%b/%h, required 0/0/0000", m2.valid, m2.last, m2.data);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({s2.ready, m2.valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL midreset_release: s_ready/m_valid=%b/%b, required 1/0", s2.ready, m2.valid);
    end
    m2.ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m2.valid) stale++;
    end
    n_checks++;
    if (stale !== 0) begin
      n_fail++;
      $display("FAIL midreset_stale: %0d stale beats, required 0", stale);
    end
    @(posedge clk); #1;
    push_exp(2, 5, 6, 7, 8, 1'b1);
    fork
      drive_beat(2, pack_in(5, 6, 7, 8), 1'b1, 4'd0);
      begin
        for (int k = 0; k < 2; k++) begin
          w = 0;
          do begin @(negedge clk); w++; end while (!(m2.valid && m2.ready) && w < 50);
          n_checks++;
          if (!(m2.valid && m2.ready) || q2.size() == 0) begin
            n_fail++;
            $display("FAIL midreset_beat%0d: m_valid=%b queued=%0d, required a beat", k, m2.valid, q2.size());
          end else begin
            e = q2.pop_front();
            $display("[%0t] post-reset beat%0d data=%h last=%b", $time, k, m2.data, m2.last);
            n_checks++;
            if ({m2.data, m2.last} !== {e.d[15:0], e.last}) begin
              n_fail++;
              $display("FAIL midreset_data%0d: data/last=%h/%b, required %h/%b", k, m2.data, m2.last, e.d[15:0], e.last);
            end
          end
        end
      end
    join
    @(posedge clk); #1;
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    shift    = 4'd0;
    rstn     = 1'b0;
    s2.valid = 1'b0; s2.last = 1'b0; s2.data = '0;
    s4.valid = 1'b0; s4.last = 1'b0; s4.data = '0;
    m2.ready = 1'b1;
    m4.ready = 1'b1;

    test_reset();
    test_requant();
    test_backpressure();
    test_back_to_back();
    test_reset_midpacket();

    n_checks++;
    if (q2.size() + q4.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q2.size() + q4.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_sa_requant.md
# axis_sa_requant

- Sits directly downstream of the systolic array.
- Consumes the array's AXI-stream of R-lane wide accumulator beats (each lane WY-bit signed).
- Per lane: arithmetic right shift by a runtime `shift`, round half-up, saturate to WO-bit signed.
- Serializes each R-lane result into R/P consecutive P-lane output beats for the narrower downstream bus, preserving packet boundaries.

## Interface

Parameters:
- R, 4: lanes per input beat (array rows).
- WY, 16: input lane width, signed.
- WO, 8: output lane width, signed.
- P, 2: lanes per output beat. R % P == 0 is required.
- SW, 4: width of `shift`. 2^SW ≥ WY.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- shift  in  SW  right-shift amount. Sampled on each input handshake. Values ≥ WY are treated as WY-1.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_last  in  1  last input beat of packet.
- s_data  in  R×WY  packed lanes; lane r = s_data[r].
- m_valid  out  1  output beat valid.
- m_ready  in  1  output beat ready.
- m_last  out  1  last output beat of packet.
- m_data  out  P×WO  output lanes.

## Operation

- Let N = R/P. Define the sub-beat counter `idx` ∈ [0, N-1].
- Requant is combinational on s_data at accept (s_valid && s_ready). The result is registered into the holding buffer q[R], together with last_q.
- Per lane arithmetic:
  - Extend to WY+1 bits.
  - If shift > 0, add 2^(shift-1); then arithmetic-shift right by shift.
  - Saturate to [-2^(WO-1), 2^(WO-1)-1].
  - Rounding is half toward +infinity (e.g. -1.5 → -1).
- Buffer state is EMPTY or FULL.
  - EMPTY, on accept → FULL, idx = 0.
  - FULL, on m_valid && m_ready with idx < N-1 → idx+1.
  - FULL, on m_valid && m_ready with idx == N-1: → FULL with idx = 0 if a new beat is accepted in the same cycle, else → EMPTY.
- s_ready = EMPTY || (m_ready && idx == N-1). The combinational path from m_ready is allowed. This gives zero-bubble streaming.
- m_valid = FULL.
- m_data[p] = q[idx*P + p] (lane 0 leaves first).
- m_last = last_q && idx == N-1. No other beat asserts m_last.
- While m_valid && !m_ready, m_data and m_last hold stable (AXI-stream rule). shift changes do not affect buffered data.
- An s_valid without s_ready is not consumed; upstream must hold s_data.

## Timing

- Reset values:
  - Asynchronous on rstn low: state EMPTY, idx 0, q all 0, last_q 0.
  - Hence m_valid 0, m_last 0, m_data 0, and s_ready 1 once rstn is high.
- Latency: input accepted at edge k → first output beat valid after edge k (visible in cycle k+1).
- Throughput: N output beats per input beat. With N = 1 and m_ready held high, one beat per cycle.
- Simultaneous last-sub-beat drain and new accept: no bubble; the new data is output starting at idx 0 the next cycle.
- Reset asserted mid-packet: the buffered beat is discarded immediately (m_valid drops without a clock edge). No partial beat or m_last appears after release.
- N = 1 degenerate case: idx is constant 0 and m_last = last_q.

## Test plan

1. R=4, P=2, shift=4, s_data = {24, 23, -24, 32767}, s_last=1, m_ready=1 → beat0 m_data = {2, 1}, m_last=0; beat1 = {-1 (0xFF), 127 (0x7F)}, m_last=1. s_ready is low during beat0.
2. shift=0, lanes {-200, 100, -128, 127} → {0x80, 0x64}, {0x80, 0x7F}: saturation only, no rounding offset.
3. Rounding edge, shift=1, lanes {-3, 3, -1, 1} → {-1, 2}, {0, 1}.
4. Backpressure: hold m_ready=0 for 5 cycles after the first m_valid → m_data/m_last constant, s_ready=0, idx frozen. Release → remaining beats emitted in order with no loss or duplication.
5. Streaming: 3 input beats back-to-back (s_last on the third), m_ready=1 → 6 output beats in 6 consecutive cycles, m_last only on the 6th. Repeat with P=4 → 3 beats in 3 cycles.
6. Assert rstn low while FULL at idx=0 → m_valid=0 immediately. After release, s_ready=1 and no stale beat is ever output.
